// File: rtl/avalon_pio_gpio.sv
// avalon_pio_gpio: Avalon-MM slave GPIO with WIDTH bidirectional bits.
// Provides a data register with atomic set/clear aliases, a per-bit
// direction register, a two-flop input synchroniser, per-bit edge capture
// and a maskable level interrupt. Writes take zero wait states and
// readdata is combinational from address.
//
// Optional build macro PIO_EDGECAP_BITCLEAR_EN:
//   defined   - writing EDGECAP clears only the bits written as 1
//   undefined - any write to EDGECAP clears every captured bit
// In both builds an edge detected in the same cycle as a clear keeps its bit set.

module avalon_pio_gpio #(
   parameter int unsigned      WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '0,
   parameter int unsigned      EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   // Register word addresses
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   // Bus-visible state
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q,      dir_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;

   // Input synchroniser and previous-sample pipeline
   logic [WIDTH-1:0] sync1_q,   sync1_d;
   logic [WIDTH-1:0] in_sync_q, in_sync_d;
   logic [WIDTH-1:0] prev_q,    prev_d;

   // Decoded bus write and per-cycle edge/clear terms
   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] edge_rise;
   logic [WIDTH-1:0] edge_fall;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] rd_field;

   // Only the low WIDTH bits of writedata reach any register
   logic             unused_writedata;
   assign unused_writedata = ^writedata;

   // Decode the write strobe and trim write data to the register width
   always_comb begin
      wr = chipselect & ~write_n;
      wd = writedata[WIDTH-1:0];
   end

   // Next values for the data, direction and mask registers from bus writes
   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      irq_mask_d = irq_mask_q;
      if (wr) begin
         case (address)
            ADDR_DATA:    data_out_d = wd;
            ADDR_DIR:     dir_d      = wd;
            ADDR_IRQMASK: irq_mask_d = wd;
            ADDR_OUTSET:  data_out_d = data_out_q | wd;
            ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
            default:      data_out_d = data_out_q;
         endcase
      end
   end

   // Bits of edge_cap that this cycle's EDGECAP write asks to clear
   always_comb begin
      clr_mask = '0;
      if (wr && (address == ADDR_EDGECAP)) begin
`ifdef PIO_EDGECAP_BITCLEAR_EN
         clr_mask = wd;
`else
         clr_mask = '1;
`endif
      end
   end

   // Synchroniser shift and one-cycle-old copy used for edge detection
   always_comb begin
      sync1_d   = in_port;
      in_sync_d = sync1_q;
      prev_d    = in_sync_q;
   end

   // Select the configured edge type; direction does not gate detection
   always_comb begin
      edge_rise = in_sync_q & ~prev_q;
      edge_fall = ~in_sync_q & prev_q;
      case (EDGE_TYPE)
         0:       edge_det = edge_rise;
         1:       edge_det = edge_fall;
         default: edge_det = edge_rise | edge_fall;
      endcase
   end

   // Capture edges; a new edge overrides a simultaneous clear so no event is lost
   always_comb begin
      edge_cap_d = (edge_cap_q & ~clr_mask) | edge_det;
   end

   // State registers; reset drops any pending captures immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RESET_VALUE;
         dir_q      <= DIR_RESET;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         sync1_q    <= '0;
         in_sync_q  <= '0;
         prev_q     <= '0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         sync1_q    <= sync1_d;
         in_sync_q  <= in_sync_d;
         prev_q     <= prev_d;
      end
   end

   // Combinational read mux; DATA shows pins for inputs and the register for outputs
   always_comb begin
      rd_field = '0;
      case (address)
         ADDR_DATA:    rd_field = (in_sync_q & ~dir_q) | (data_out_q & dir_q);
         ADDR_DIR:     rd_field = dir_q;
         ADDR_IRQMASK: rd_field = irq_mask_q;
         ADDR_EDGECAP: rd_field = edge_cap_q;
         default:      rd_field = '0;
      endcase
      readdata              = '0;
      readdata[WIDTH-1:0]   = rd_field;
   end

   // Pin-facing outputs and the level interrupt
   always_comb begin
      out_port = data_out_q;
      oe       = dir_q;
      irq      = |(edge_cap_q & irq_mask_q);
   end

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Self-checking bench for avalon_pio_gpio (WIDTH=8, RESET_VALUE=A5,
// DIR_RESET=F0, EDGE_TYPE=rising). A behavioural model tracks register
// contents and a history of sampled pin values.

module tb_avalon_pio_gpio;

   localparam int         W   = 8;
   localparam logic [7:0] RV  = 8'hA5;
   localparam logic [7:0] DR  = 8'hF0;
   localparam int         ET  = 0;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic [7:0]  oe;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;

   // Model state
   logic [7:0] m_data, m_dir, m_mask, m_cap;
   logic [7:0] pin_hist[$];

   avalon_pio_gpio #(
      .WIDTH      (W),
      .RESET_VALUE(RV),
      .DIR_RESET  (DR),
      .EDGE_TYPE  (ET)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .out_port  (out_port),
      .oe        (oe),
      .irq       (irq)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic model_reset();
      m_data   = RV;
      m_dir    = DR;
      m_mask   = 8'h00;
      m_cap    = 8'h00;
      pin_hist = '{8'h00, 8'h00, 8'h00};
   endtask

   // Pin seen on the register side now is the one sampled two clocks ago
   function automatic logic [7:0] model_pins();
      return pin_hist[1];
   endfunction

   // Advance the model by one clock using the bus/pin values present at the edge
   task automatic model_clock();
      logic [7:0] now_v, old_v, ev, clr, d8;
      logic       wr_m;
      now_v = pin_hist[1];
      old_v = pin_hist[2];
      if (ET == 0)      ev = now_v & ~old_v;
      else if (ET == 1) ev = ~now_v & old_v;
      else              ev = now_v ^ old_v;
      wr_m = chipselect && !write_n;
      d8   = writedata[7:0];
      clr  = 8'h00;
      if (wr_m && address == 3'd3) begin
`ifdef PIO_EDGECAP_BITCLEAR_EN
         clr = d8;
`else
         clr = 8'hFF;
`endif
      end
      m_cap = (m_cap & ~clr) | ev;
      if (wr_m) begin
         case (address)
            3'd0: m_data = d8;
            3'd1: m_dir  = d8;
            3'd2: m_mask = d8;
            3'd4: m_data = m_data | d8;
            3'd5: m_data = m_data & ~d8;
            default: ;
         endcase
      end
      pin_hist.push_front(in_port);
      void'(pin_hist.pop_back());
   endtask

   function automatic logic [31:0] model_read(input logic [2:0] a);
      logic [31:0] r;
      r = 32'h0;
      case (a)
         3'd0: r[7:0] = (model_pins() & ~m_dir) | (m_data & m_dir);
         3'd1: r[7:0] = m_dir;
         3'd2: r[7:0] = m_mask;
         3'd3: r[7:0] = m_cap;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic model_irq();
      return |(m_cap & m_mask);
   endfunction

   // Drive one bus cycle plus pin value, clock it, and leave the bus idle at edge+1
   task automatic applyStimulus(input logic w, input logic [2:0] a,
                                input logic [31:0] d, input logic [7:0] p);
      chipselect = w;
      write_n    = ~w;
      address    = a;
      writedata  = d;
      in_port    = p;
      @(posedge clk);
      model_clock();
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Combinational read, sampled 1ns after presenting the address
   task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = a;
      #1;
      v          = readdata;
      chipselect = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd0;
      writedata  = 32'h0;
      in_port    = 8'h00;
      model_reset();
      #12;
      vectors++;
      if (out_port !== 8'hA5) begin
         miscompares++;
         $display("[TB] FAIL reset_out_port: got %h expected %h", out_port, 8'hA5);
      end
      vectors++;
      if (oe !== 8'hF0) begin
         miscompares++;
         $display("[TB] FAIL reset_oe: got %h expected %h", oe, 8'hF0);
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_irq: got %b expected 0", irq);
      end
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(1'b0, 3'd0, 32'h0, 8'h00);
      bus_read(3'd1, v);
      vectors++;
      if (v !== 32'h0000_00F0) begin
         miscompares++;
         $display("[TB] FAIL reset_read_dir: got %h expected %h", v, 32'h0000_00F0);
      end
      bus_read(3'd3, v);
      vectors++;
      if (v !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_read_edgecap: got %h expected %h", v, 32'h0);
      end
   endtask

   task automatic test_set_clear();
      logic [31:0] v;
      applyStimulus(1'b1, 3'd0, 32'hFFFF_FF3C, 8'h00);
      vectors++;
      if (out_port !== 8'h3C) begin
         miscompares++;
         $display("[TB] FAIL data_write: got %h expected %h", out_port, 8'h3C);
      end
      applyStimulus(1'b1, 3'd4, 32'h0000_0003, 8'h00);
      vectors++;
      if (out_port !== 8'h3F) begin
         miscompares++;
         $display("[TB] FAIL outset: got %h expected %h", out_port, 8'h3F);
      end
      applyStimulus(1'b1, 3'd5, 32'h0000_000C, 8'h00);
      vectors++;
      if (out_port !== 8'h33) begin
         miscompares++;
         $display("[TB] FAIL outclr: got %h expected %h", out_port, 8'h33);
      end
      applyStimulus(1'b1, 3'd1, 32'h0000_00FF, 8'h00);
      bus_read(3'd0, v);
      vectors++;
      if (v !== 32'h0000_0033) begin
         miscompares++;
         $display("[TB] FAIL read_data_all_out: got %h expected %h", v, 32'h0000_0033);
      end
      bus_read(3'd4, v);
      vectors++;
      if (v !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL read_outset_zero: got %h expected %h", v, 32'h0);
      end
   endtask

   task automatic test_mixed_dir();
      logic [31:0] v;
      applyStimulus(1'b1, 3'd1, 32'h0000_000F, 8'h00);
      applyStimulus(1'b1, 3'd0, 32'h0000_0005, 8'h00);
      applyStimulus(1'b0, 3'd0, 32'h0, 8'hA0);
      applyStimulus(1'b0, 3'd0, 32'h0, 8'hA0);
      bus_read(3'd0, v);
      vectors++;
      if (v !== 32'h0000_00A5) begin
         miscompares++;
         $display("[TB] FAIL mixed_dir_read: got %h expected %h", v, 32'h0000_00A5);
      end
      vectors++;
      if (v !== model_read(3'd0)) begin
         miscompares++;
         $display("[TB] FAIL mixed_dir_model: got %h expected %h", v, model_read(3'd0));
      end
   endtask

   task automatic test_edge_latency();
      logic [31:0] v;
      applyStimulus(1'b1, 3'd2, 32'h0000_0001, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h00);
      applyStimulus(1'b1, 3'd3, 32'h0000_00FF, 8'h00);
      // Rising pin presented before edge N
      applyStimulus(1'b0, 3'd0, 32'h0, 8'h01);
      bus_read(3'd3, v);
      vectors++;
      if (irq !== 1'b0 || v[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_edge_n: got irq=%b cap=%h expected irq=0 cap=00", irq, v[7:0]);
      end
      applyStimulus(1'b0, 3'd0, 32'h0, 8'h01);
      bus_read(3'd3, v);
      vectors++;
      if (irq !== 1'b0 || v[0] !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_edge_n1: got irq=%b cap=%h expected irq=0 cap=00", irq, v[7:0]);
      end
      applyStimulus(1'b0, 3'd0, 32'h0, 8'h01);
      bus_read(3'd3, v);
      vectors++;
      if (irq !== 1'b1 || v !== 32'h0000_0001) begin
         miscompares++;
         $display("[TB] FAIL latency_edge_n2: got irq=%b cap=%h expected irq=1 cap=00000001", irq, v);
      end
      applyStimulus(1'b1, 3'd3, 32'h0000_0001, 8'h01);
      // Falling edge must not be captured
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h00);
      bus_read(3'd3, v);
      vectors++;
      if (irq !== 1'b0 || v !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL falling_ignored: got irq=%b cap=%h expected irq=0 cap=00000000", irq, v);
      end
   endtask

   task automatic test_clear_collision();
      logic [31:0] v;
      // First rise sets the captured bit
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h01);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h00);
      // Second rise: its detection lands on the cycle of the EDGECAP write
      applyStimulus(1'b0, 3'd0, 32'h0, 8'h01);
      applyStimulus(1'b0, 3'd0, 32'h0, 8'h01);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL collision_pre_irq: got %b expected 1", irq);
      end
      applyStimulus(1'b1, 3'd3, 32'h0000_0001, 8'h01);
      bus_read(3'd3, v);
      vectors++;
      if (v[0] !== 1'b1 || irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL collision_keep: got cap0=%b irq=%b expected cap0=1 irq=1", v[0], irq);
      end
      vectors++;
      if (v !== model_read(3'd3)) begin
         miscompares++;
         $display("[TB] FAIL collision_model: got %h expected %h", v, model_read(3'd3));
      end
   endtask

   task automatic test_clear_semantics();
      logic [31:0] v;
      logic [31:0] exp_cap;
      logic        exp_irq;
`ifdef PIO_EDGECAP_BITCLEAR_EN
      exp_cap = 32'h0000_0002;
      exp_irq = 1'b1;
`else
      exp_cap = 32'h0000_0000;
      exp_irq = 1'b0;
`endif
      applyStimulus(1'b1, 3'd2, 32'h0000_0000, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h00);
      applyStimulus(1'b1, 3'd3, 32'h0000_00FF, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h03);
      bus_read(3'd3, v);
      vectors++;
      if (v !== 32'h0000_0003 || irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL capture_masked: got cap=%h irq=%b expected cap=00000003 irq=0", v, irq);
      end
      // Unmasking an already-captured bit raises irq after the write edge
      applyStimulus(1'b1, 3'd2, 32'h0000_0002, 8'h03);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL unmask_irq: got %b expected 1", irq);
      end
      applyStimulus(1'b1, 3'd3, 32'h0000_0001, 8'h03);
      bus_read(3'd3, v);
      vectors++;
      if (v !== exp_cap) begin
         miscompares++;
         $display("[TB] FAIL clear_semantics: got %h expected %h", v, exp_cap);
      end
      vectors++;
      if (irq !== exp_irq) begin
         miscompares++;
         $display("[TB] FAIL clear_irq: got %b expected %b", irq, exp_irq);
      end
   endtask

   task automatic test_random();
      logic [31:0] v, d, e;
      logic [2:0]  a, ra;
      logic [7:0]  p;
      logic        w;
      p = 8'h03;
      for (int i = 0; i < 300; i++) begin
         w = 1'($urandom_range(0, 1));
         a = 3'($urandom_range(0, 7));
         d = $urandom;
         if ($urandom_range(0, 2) == 0) p = 8'($urandom);
         applyStimulus(w, a, d, p);
         vectors++;
         if (out_port !== m_data) begin
            miscompares++;
            $display("[TB] FAIL rand_out_port[%0d]: got %h expected %h", i, out_port, m_data);
         end
         vectors++;
         if (oe !== m_dir) begin
            miscompares++;
            $display("[TB] FAIL rand_oe[%0d]: got %h expected %h", i, oe, m_dir);
         end
         vectors++;
         if (irq !== model_irq()) begin
            miscompares++;
            $display("[TB] FAIL rand_irq[%0d]: got %b expected %b", i, irq, model_irq());
         end
         ra = 3'($urandom_range(0, 7));
         bus_read(ra, v);
         e = model_read(ra);
         vectors++;
         if (v !== e) begin
            miscompares++;
            $display("[TB] FAIL rand_read[%0d] addr %0d: got %h expected %h", i, ra, v, e);
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] v;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF);
      applyStimulus(1'b1, 3'd2, 32'h0000_00FF, 8'hFF);
      applyStimulus(1'b1, 3'd0, 32'h0000_005A, 8'hFF);
      applyStimulus(1'b1, 3'd1, 32'h0000_003C, 8'hFF);
      vectors++;
      if (irq !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midop_pre_irq: got %b expected 1", irq);
      end
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (out_port !== 8'hA5 || oe !== 8'hF0 || irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL midop_reset: got out=%h oe=%h irq=%b expected out=a5 oe=f0 irq=0", out_port, oe, irq);
      end
      bus_read(3'd3, v);
      vectors++;
      if (v !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL midop_cap_cleared: got %h expected %h", v, 32'h0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      // Synchroniser restarts from zero, so the held-high pins look like a fresh rise
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 3'd0, 32'h0, 8'hFF);
      bus_read(3'd3, v);
      vectors++;
      if (v !== model_read(3'd3)) begin
         miscompares++;
         $display("[TB] FAIL midop_recapture: got %h expected %h", v, model_read(3'd3));
      end
   endtask

   // Run every scenario in order and report
   initial begin
      test_reset();
      test_set_clear();
      test_mixed_dir();
      test_edge_latency();
      test_clear_collision();
      test_clear_semantics();
      test_random();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/avalon_pio_gpio.md
Name: avalon_pio_gpio

Overview:
Parametrised Avalon-MM slave GPIO. It generalises the 8-bit output-only PIO to WIDTH bidirectional bits, with a per-bit direction register, atomic set/clear of output bits, synchronised input sampling, edge capture, and a maskable level interrupt. It sits in the Qsys system next to the existing PIO and is driven by the same HPS/bridge master.
- Zero-wait-state writes.
- Read latency 0: readdata is combinational from address.

Parameters:
WIDTH, 8, number of GPIO bits (1..32).
RESET_VALUE, 0, reset value of the output data register.
DIR_RESET, 0, reset value of the direction register (1 = output).
EDGE_TYPE, 0, captured edge: 0 rising, 1 falling, 2 any.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  output data register
oe  out  WIDTH  output enables (direction register)
irq  out  1  level interrupt, active high

Behaviour:
- Reset: clk and reset_n are the only clock and reset.
  - reset_n low asynchronously sets data_out = RESET_VALUE, dir = DIR_RESET, irq_mask = 0, edge_cap = 0.
  - Synchroniser and previous-sample flops reset to 0.
  - Consequence: out_port = RESET_VALUE, oe = DIR_RESET, irq = 0.
  - reset_n asserted mid-operation discards pending captures immediately.
- Write strobe: wr = chipselect & ~write_n. Register files use writedata[WIDTH-1:0]; upper bits are ignored.
- Register map:
  - addr 0 DATA:
    - read = (in_sync & ~dir) | (data_out & dir).
    - write loads data_out.
  - addr 1 DIR: r/w.
  - addr 2 IRQMASK: r/w.
  - addr 3 EDGECAP:
    - read returns edge_cap.
    - write clears (see Optional Feature).
  - addr 4 OUTSET: write sets data_out |= wd; read 0.
  - addr 5 OUTCLR: write sets data_out &= ~wd; read 0.
  - addr 6,7: reserved; read 0, writes ignored.
- readdata bits [31:WIDTH] always 0. Reads have no side effects.
- Input path:
  - in_port passes through a 2-flop synchroniser: sync1 -> in_sync. prev <= in_sync every cycle.
  - Edge detect per bit:
    - rise = in_sync & ~prev
    - fall = ~in_sync & prev
    - any = rise | fall
    - EDGE_TYPE selects which of these is used.
  - Edges are detected on all bits regardless of dir.
- edge_cap update per bit, each clock:
  - next = (edge_cap & ~clr_mask) | edge.
  - A detected edge in the same cycle as a clear leaves the bit set: events are never lost.
- Latency: an in_port change before clock edge N appears in in_sync after edge N+1. edge_cap sets after edge N+2, and irq is valid after edge N+2.
- irq = |(edge_cap & irq_mask[WIDTH-1:0]), combinational from registers.
- Unmasking a bit that is already captured raises irq in the cycle after the IRQMASK write.
- OUTSET/OUTCLR take effect on the clock edge of the write. out_port updates the cycle after.

Optional Feature:
Macro PIO_EDGECAP_BITCLEAR_EN.
- Defined: a write to EDGECAP clears only the bits written 1 (clr_mask = wd).
- Undefined: any write to EDGECAP clears all bits (clr_mask = all ones).
- Set-wins-over-clear applies in both builds.

Test Plan:
1. Reset values:
   - Stimulus: WIDTH=8, RESET_VALUE=8'hA5, DIR_RESET=8'hF0; hold reset_n low, then release.
   - Required: out_port=A5, oe=F0, irq=0; read addr1 -> 0x000000F0, addr3 -> 0.
2. Atomic set/clear and width masking:
   - Stimulus: write DATA=0xFFFF_FF3C, then OUTSET=0x03, then OUTCLR=0x0C.
   - Required: out_port goes 3C, 3F, 33; read addr0 with dir=FF returns 0x00000033.
3. Mixed-direction read:
   - Stimulus: dir=0x0F, data_out=0x05, in_port=0xA0, wait 2 clocks.
   - Required: read addr0 = 0x000000A5.
4. Edge capture and irq latency:
   - Stimulus: EDGE_TYPE=0, irq_mask=0x01; in_port[0] rises before edge N.
   - Required: edge_cap[0]=1 and irq=1 after edge N+2, not before. A falling edge is not captured.
5. Simultaneous clear and edge:
   - Stimulus: a write to EDGECAP=0x01 in the same cycle a new bit-0 edge is detected.
   - Required: edge_cap[0] stays 1 and irq stays high.
6. Clear semantics:
   - Stimulus: edge_cap=0x03, write EDGECAP=0x01.
   - Required: result 0x02 with PIO_EDGECAP_BITCLEAR_EN defined; 0x00 without.
